// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard receiver and scancode FIFO; optional break-code folding under PS2_BREAK_FOLD_EN

module ps2_kbd_fifo #(
    parameter int FIFO_AW = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       rd,
    output logic [7:0] o_data,
    output logic       ready,
    output logic       drop
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wp;
    logic [FIFO_AW:0] rp;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_write;

    assign empty    = (wp == rp);
    assign full     = (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]) && (wp[FIFO_AW] != rp[FIFO_AW]);
    assign do_pop   = rd && !empty;
    // A pop in the same cycle frees the head slot, so a push while full still lands.
    assign do_write = push && (!full || do_pop);
    assign drop     = push && full && !do_pop;

    assign ready  = !empty;
    assign o_data = empty ? 8'h00 : mem[rp[FIFO_AW-1:0]];

    // Storage array and pointer update.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (do_write) begin
                mem[wp[FIFO_AW-1:0]] <= push_data;
                wp                   <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
        end
    end

endmodule

module ps2_kbd_rx #(
    parameter int FIFO_AW        = 3,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       rd,
    input  logic       clr,
    output logic [7:0] o_data,
    output logic       ready,
    output logic       overflow,
    output logic       err,
    output logic       irq
);

    localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(FILTER_LEN - 1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic             clk_s1, clk_s2;
    logic             dat_s1, dat_s2;
    logic             filt_clk;
    logic [FLT_W-1:0] filt_cnt;
    logic             fall_evt;

    state_t           state, state_nx;
    logic [2:0]       bitcnt, bitcnt_nx;
    logic [7:0]       sr, sr_nx;
    logic             par_bit, par_nx;
    logic             par_ok;
    logic [WD_W-1:0]  wdog, wdog_nx;
    logic             frame_ok;
    logic             frame_err;
    logic             push;
    logic [7:0]       push_byte;
    logic             drop;

`ifdef PS2_BREAK_FOLD_EN
    logic             brk, brk_nx;
`endif

    // Two-flop synchronizers; idle PS/2 lines sit high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter: filtered clock follows only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 != filt_clk) begin
            if (filt_cnt == FLT_MAX) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    // Fall event is the cycle in which the filtered clock is about to drop.
    assign fall_evt = filt_clk && !clk_s2 && (filt_cnt == FLT_MAX);
    assign par_ok   = ^{sr, par_bit};

    // Frame state register and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            bitcnt  <= 3'd0;
            sr      <= 8'h00;
            par_bit <= 1'b0;
            wdog    <= '0;
        end else begin
            state   <= state_nx;
            bitcnt  <= bitcnt_nx;
            sr      <= sr_nx;
            par_bit <= par_nx;
            wdog    <= wdog_nx;
        end
    end

    // Deframing next-state logic, watchdog and frame completion decode.
    always_comb begin
        state_nx  = state;
        bitcnt_nx = bitcnt;
        sr_nx     = sr;
        par_nx    = par_bit;
        frame_ok  = 1'b0;
        frame_err = 1'b0;

        if (state == S_IDLE || fall_evt) begin
            wdog_nx = '0;
        end else begin
            wdog_nx = wdog + 1'b1;
        end

        if (fall_evt) begin
            case (state)
                S_IDLE: begin
                    // A high data bit on a fall is a spurious edge, not a start bit.
                    if (!dat_s2) begin
                        state_nx  = S_DATA;
                        bitcnt_nx = 3'd0;
                    end
                end
                S_DATA: begin
                    sr_nx     = {dat_s2, sr[7:1]};
                    bitcnt_nx = bitcnt + 1'b1;
                    if (bitcnt == 3'd7) begin
                        state_nx = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_nx   = dat_s2;
                    state_nx = S_STOP;
                end
                S_STOP: begin
                    state_nx = S_IDLE;
                    if (dat_s2 && par_ok) begin
                        frame_ok = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end else if (state != S_IDLE && wdog == WD_MAX) begin
            state_nx  = S_IDLE;
            wdog_nx   = '0;
            frame_err = 1'b1;
        end
    end

`ifdef PS2_BREAK_FOLD_EN
    // Break prefix is swallowed and folded into bit 7 of the following code; E0 passes through.
    always_comb begin
        brk_nx    = brk;
        push      = 1'b0;
        push_byte = sr;
        if (frame_ok) begin
            if (sr == 8'hF0) begin
                brk_nx = 1'b1;
            end else if (sr == 8'hE0) begin
                push = 1'b1;
            end else begin
                push      = 1'b1;
                push_byte = {sr[7] | brk, sr[6:0]};
                brk_nx    = 1'b0;
            end
        end else if (frame_err) begin
            brk_nx = 1'b0;
        end
    end

    // Break-pending flag register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            brk <= 1'b0;
        end else begin
            brk <= brk_nx;
        end
    end
`else
    assign push      = frame_ok;
    assign push_byte = sr;
`endif

    ps2_kbd_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_byte),
        .rd        (rd),
        .o_data    (o_data),
        .ready     (ready),
        .drop      (drop)
    );

    // Sticky status flags (set wins over clr) and the registered push interrupt.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err      <= 1'b0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            err      <= frame_err | (err & ~clr);
            overflow <= drop | (overflow & ~clr);
            irq      <= push;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - self-checking bench for ps2_kbd_rx

module tb_ps2_kbd_rx;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       rd = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] o_data;
    logic       ready;
    logic       overflow;
    logic       err;
    logic       irq;

    int checks = 0;
    int failures = 0;
    int irq_seen = 0;
    int irq_exp = 0;
    bit ovf_exp = 1'b0;
    bit m_brk = 1'b0;
    logic [7:0] exp_q[$];

    ps2_kbd_rx dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .rd       (rd),
        .clr      (clr),
        .o_data   (o_data),
        .ready    (ready),
        .overflow (overflow),
        .err      (err),
        .irq      (irq)
    );

    always #20 clock = ~clock;

    always @(posedge clock) begin
        #1;
        if (irq === 1'b1) irq_seen++;
    end

    initial begin
        #6000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            ps2_dat = bits[i];
            wait_cycles(half);
            ps2_clk = 1'b0;
            wait_cycles(half);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int half);
        logic       par;
        logic [10:0] bits;
        par  = ~(^b) ^ bad_par;
        bits = {1'b1, par, b, 1'b0};
        send_bits(bits, 11, half);
        wait_cycles(half);
        ps2_dat = 1'b1;
        wait_cycles(20);
    endtask

    // Reference model of what a valid frame should leave in the queue.
    task automatic model_valid(input logic [7:0] b);
        logic [7:0] v;
        v = b;
`ifdef PS2_BREAK_FOLD_EN
        if (v == 8'hF0) begin
            m_brk = 1'b1;
            return;
        end
        if (v != 8'hE0) begin
            if (m_brk) v = v | 8'h80;
            m_brk = 1'b0;
        end
`endif
        irq_exp++;
        if (exp_q.size() < 8) exp_q.push_back(v);
        else ovf_exp = 1'b1;
    endtask

    task automatic good_frame(input logic [7:0] b, input int half);
        model_valid(b);
        send_frame(b, 1'b0, half);
    endtask

    task automatic read_one(input string tag);
        logic [7:0] e;
        @(negedge clock);
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, {24'd0, o_data}, {24'd0, e});
        end
        rd = 1'b1;
        @(negedge clock);
        rd = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) read_one(tag);
        @(negedge clock);
        check({tag, "_empty_ready"}, {31'd0, ready}, 32'd0);
        check({tag, "_empty_data"}, {24'd0, o_data}, 32'd0);
        check({tag, "_irq_count"}, irq_seen, irq_exp);
    endtask

    task automatic pulse_clr();
        @(negedge clock);
        clr = 1'b1;
        @(negedge clock);
        clr = 1'b0;
    endtask

    initial begin
        wait_cycles(5);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_data", {24'd0, o_data}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        wait_cycles(5);

        // A make code at a 10 kHz PS/2 clock.
        good_frame(8'h1C, 1250);
        check("a_irq", irq_seen, irq_exp);
        drain("a");

        // Bad parity: no push, sticky err until clr.
        send_frame(8'h1C, 1'b1, 40);
        @(negedge clock);
        check("par_err", {31'd0, err}, 32'd1);
        check("par_ready", {31'd0, ready}, 32'd0);
        check("par_irq", irq_seen, irq_exp);
        pulse_clr();
        check("par_clr", {31'd0, err}, 32'd0);

        // Nine frames into an eight-entry FIFO.
        for (int i = 1; i <= 9; i++) good_frame(8'(i), 40);
        @(negedge clock);
        check("ovf_flag", {31'd0, overflow}, {31'd0, ovf_exp});
        check("ovf_err", {31'd0, err}, 32'd0);
        drain("ovf");
        pulse_clr();
        check("ovf_clr", {31'd0, overflow}, 32'd0);

        // Partial frame then a stalled clock trips the watchdog.
        send_bits(11'b000_0000_1010, 5, 40);
        wait_cycles(30000);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_ready", {31'd0, ready}, 32'd0);
        m_brk = 1'b0;
        pulse_clr();
        check("to_clr", {31'd0, err}, 32'd0);
        good_frame(8'h29, 40);
        drain("to_next");

        // Short clock glitch with data low must not start a frame.
        @(negedge clock);
        ps2_dat = 1'b0;
        wait_cycles(3);
        ps2_clk = 1'b0;
        wait_cycles(2);
        ps2_clk = 1'b1;
        wait_cycles(20);
        ps2_dat = 1'b1;
        check("gl_err", {31'd0, err}, 32'd0);
        check("gl_ready", {31'd0, ready}, 32'd0);
        good_frame(8'h5A, 40);
        drain("gl_next");
        check("gl_err_after", {31'd0, err}, 32'd0);

        // Break and extended prefixes.
        good_frame(8'hF0, 40);
        good_frame(8'h1C, 40);
        good_frame(8'hE0, 40);
        good_frame(8'hF0, 40);
        good_frame(8'h75, 40);
        drain("brk");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- PS/2 keyboard receiver and scancode FIFO on the `clock_25` domain.
- Sits directly upstream of the cpu core, which reads scancodes through its I/O port 60h/64h decode.
- Samples the board's `ps2_keyb_clk`/`ps2_keyb_dat` pins, deframes 11-bit PS/2 frames and queues validated bytes.
- The head byte is presented first-word-fall-through to the CPU read path.

Parameters:
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries (8).
- FILTER_LEN, 4, number of consecutive identical synced samples required before the filtered ps2 clock changes.
- TIMEOUT_CYCLES, 25000, clock cycles without a falling edge mid-frame before the frame is aborted (1 ms at 25 MHz).

Ports:
- clock  in  1  system clock (25 MHz).
- reset_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous).
- ps2_dat  in  1  raw PS/2 data pin (asynchronous).
- rd  in  1  one-cycle pop strobe from CPU port-60h read.
- clr  in  1  one-cycle strobe; clears sticky `overflow` and `err`.
- o_data  out  8  FIFO head byte; 8'h00 when empty.
- ready  out  1  FIFO non-empty.
- overflow  out  1  sticky: a valid byte was dropped because the FIFO was full.
- err  out  1  sticky: parity, stop or timeout error.
- irq  out  1  one-cycle pulse per byte pushed.

Behaviour:
- Reset: clock and reset are `clock` and `reset_n`; reset is asynchronous, active-low, and affects all flops.
  - While `reset_n`=0, all outputs are 0, the FIFO is empty, the FSM is IDLE, filtered clk = 1 and all counters = 0.
  - Reset asserted mid-frame discards the partial frame.
- Input sync: `ps2_clk` and `ps2_dat` each pass through a 2-flop synchronizer.
- Clock filter:
  - A counter tracks how long the synced clk has differed from the filtered clk.
  - When the difference persists for FILTER_LEN cycles, the filtered clk takes the new value and the counter resets.
  - A fall event is a 1->0 transition of the filtered clk.
  - Data is sampled from the synced `ps2_dat` in the same cycle as the fall event.
- FSM (advances only on fall events, except timeout):
  - IDLE: data=0 -> DATA with bitcnt=0. Data=1 -> stay in IDLE (spurious edge, no error).
  - DATA: shift right into sr, so bit 7 is written first and the LSB arrives first. bitcnt increments; after the 8th bit -> PARITY.
  - PARITY: store the bit; `par_ok` = XOR of the 8 data bits and the parity bit equals 1 (odd parity). -> STOP.
  - STOP: data=1 and par_ok -> push sr. Otherwise set `err` and do not push. -> IDLE.
- Timeout: in any state other than IDLE, a watchdog counts cycles and resets to 0 on each fall event.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE, `err`=1, nothing pushed.
  - The watchdog is held at 0 in IDLE.
- FIFO:
  - Registered pointers wp and rp are FIFO_AW+1 bits wide.
  - Empty when wp==rp. Full when the pointers' low bits are equal and their MSBs differ.
  - A push is written at wp[FIFO_AW-1:0] and increments wp.
  - A push while full drops the byte and sets `overflow`; wp is unchanged and `irq` still fires for the dropped byte.
  - `rd` while not empty increments rp. `rd` while empty is ignored.
  - Push and `rd` in the same cycle are both performed, so the count is unchanged; this is legal even when full, because the pop frees the slot first.
- Outputs:
  - `o_data` = mem[rp] when not empty, else 8'h00 (combinational from registers).
  - `ready` = !empty.
  - `irq` is registered, high for the cycle after the push cycle.
- Sticky flags: `clr` clears them. A same-cycle set and `clr` leaves the flag = 1 (set wins).
- Latency: the pushed byte is visible on `o_data`/`ready` the cycle after the STOP fall event.

Optional Feature:
- Macro: PS2_BREAK_FOLD_EN.
- Defined:
  - A valid byte 8'hF0 is not pushed, produces no `irq`, and arms a `brk` flag.
  - The next valid byte is pushed with bit 7 forced to 1; `brk` is then cleared.
  - 8'hE0 is pushed normally and does not clear `brk`.
  - An error frame or timeout clears `brk`.
  - `brk` resets to 0.
- Not defined: all valid bytes, including F0, are pushed unmodified, and no `brk` logic exists.

Test Plan:
- Frame 8'h1C (A make), odd parity bit 0, stop 1, 10 kHz PS/2 clock -> `ready`=1, `o_data`=8'h1C, one `irq` pulse; `rd` -> `ready`=0, `o_data`=8'h00.
- Frame 8'h1C with parity bit 1 -> no push, `err`=1; `clr` -> `err`=0.
- 9 valid frames 8'h01..8'h09 with no reads -> entries 01..08 queued, `overflow`=1; 8 `rd` strobes return 01..08 in order, then `ready`=0.
- Start bit and 4 data bits, then clk held high for 30000 cycles -> `err`=1, FSM back in IDLE; a following good frame 8'h29 is received correctly.
- 2-cycle low glitch on `ps2_clk` with FILTER_LEN=4 -> no bit shifted, no error.
- With PS2_BREAK_FOLD_EN: frames F0,1C -> single entry 8'h9C; frames E0,F0,75 -> entries E0, F5. Without the macro: F0,1C -> entries F0, 1C.
